// File: rtl/rheed_pkg.sv
// Shared constants and beat layout for the RHEED result packer.
package rheed_pkg;
  localparam int RESULT_W       = 40;
  localparam int BEAT_W         = 256;
  localparam int SLOTS_PER_BEAT = 6;
  localparam int CNT_LSB        = 240;
  localparam int IDX_LSB        = 244;

  typedef struct packed {
    logic [11:0]          frame_idx;
    logic [3:0]           count;
    logic [5:0][39:0]     slot;
  } rheed_beat_t;
endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register: load fills it, a ready handshake drains it.
module axis_out_reg #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         drain,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;

  // A load wins over a drain on the same cycle: the new beat replaces the old one.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;
endmodule

// File: rtl/rheed_result_packer.sv
// Packs 40-bit CNN results six to a 256-bit beat, with slot count, frame index and tlast.
module rheed_result_packer
  import rheed_pkg::*;
#(
  parameter int RESULTS_PER_FRAME = 1,
  parameter int FRAME_IDX_W       = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [RESULT_W-1:0]    s_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [BEAT_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   frame_done,
  output logic [FRAME_IDX_W-1:0] frame_idx
);
  localparam int RCW = (RESULTS_PER_FRAME > 1) ? $clog2(RESULTS_PER_FRAME) : 1;
  localparam logic [RCW-1:0] RES_LAST  = RCW'(RESULTS_PER_FRAME - 1);
  localparam logic [2:0]     SLOT_LAST = 3'(SLOTS_PER_BEAT - 1);

  logic [2:0]                                slot_cnt_q, slot_cnt_d;
  logic [RCW-1:0]                            res_cnt_q, res_cnt_d;
  logic [FRAME_IDX_W-1:0]                    frame_idx_q, frame_idx_d;
  logic [SLOTS_PER_BEAT-1:0][RESULT_W-1:0]   pack_q, pack_d, merged;
  logic                                      frame_done_q, frame_done_d;
  logic                                      s_hs, last_res, complete;
  logic [BEAT_W-1:0]                         beat;

  // Input stalls whenever the output is blocked, so a load never overwrites an undrained beat.
  assign s_axis_tready = !reset && (!m_axis_tvalid || m_axis_tready);

  always_comb begin
    s_hs     = s_axis_tvalid && s_axis_tready;
    last_res = (res_cnt_q == RES_LAST);
    complete = s_hs && ((slot_cnt_q == SLOT_LAST) || last_res);

    merged             = pack_q;
    merged[slot_cnt_q] = s_axis_tdata;

    beat                           = '0;
    beat[CNT_LSB-1:0]              = merged;
    beat[CNT_LSB +: 4]             = {1'b0, slot_cnt_q} + 4'd1;
    beat[IDX_LSB +: FRAME_IDX_W]   = frame_idx_q;

    slot_cnt_d  = slot_cnt_q;
    res_cnt_d   = res_cnt_q;
    frame_idx_d = frame_idx_q;
    pack_d      = pack_q;
    if (s_hs) begin
      if (complete) begin
        pack_d     = '0;
        slot_cnt_d = '0;
      end else begin
        pack_d     = merged;
        slot_cnt_d = slot_cnt_q + 3'd1;
      end
      if (last_res) begin
        res_cnt_d   = '0;
        frame_idx_d = frame_idx_q + 1'b1;
      end else begin
        res_cnt_d = res_cnt_q + 1'b1;
      end
    end

    frame_done_d = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_q   <= '0;
      res_cnt_q    <= '0;
      frame_idx_q  <= '0;
      pack_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      res_cnt_q    <= res_cnt_d;
      frame_idx_q  <= frame_idx_d;
      pack_q       <= pack_d;
      frame_done_q <= frame_done_d;
    end
  end

  axis_out_reg #(.W(BEAT_W)) u_out (
    .clk       (clk),
    .rst       (reset),
    .load      (complete),
    .load_data (beat),
    .load_last (last_res),
    .drain     (m_axis_tready),
    .valid     (m_axis_tvalid),
    .data      (m_axis_tdata),
    .last      (m_axis_tlast)
  );

  assign frame_done = frame_done_q;
  assign frame_idx  = frame_idx_q;
endmodule

// File: tb/tb_rheed_result_packer.sv
// Directed bench: three packer instances (1, 13 and 6 results per frame) on one clock and reset.
module tb_rheed_result_packer;
  import rheed_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        s_valid[3], s_ready[3], m_valid[3], m_ready[3], m_last[3], fd[3];
  logic [39:0]  s_data[3];
  logic [255:0] m_data[3];
  logic [11:0]  fidx[3];

  logic [256:0] q0[$], q1[$], q2[$];
  int acc[3] = '{0, 0, 0};
  int n_cmp = 0, n_err = 0;

  rheed_result_packer #(.RESULTS_PER_FRAME(1)) u_rpf1 (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]), .s_axis_tdata(s_data[0]),
    .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]), .m_axis_tdata(m_data[0]),
    .m_axis_tlast(m_last[0]), .frame_done(fd[0]), .frame_idx(fidx[0]));

  rheed_result_packer #(.RESULTS_PER_FRAME(13)) u_rpf13 (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]), .s_axis_tdata(s_data[1]),
    .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]), .m_axis_tdata(m_data[1]),
    .m_axis_tlast(m_last[1]), .frame_done(fd[1]), .frame_idx(fidx[1]));

  rheed_result_packer #(.RESULTS_PER_FRAME(6)) u_rpf6 (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_valid[2]), .s_axis_tready(s_ready[2]), .s_axis_tdata(s_data[2]),
    .m_axis_tvalid(m_valid[2]), .m_axis_tready(m_ready[2]), .m_axis_tdata(m_data[2]),
    .m_axis_tlast(m_last[2]), .frame_done(fd[2]), .frame_idx(fidx[2]));

  // Capture every output handshake and count accepted inputs.
  always @(posedge clk) begin
    if (m_valid[0] && m_ready[0]) q0.push_back({m_last[0], m_data[0]});
    if (m_valid[1] && m_ready[1]) q1.push_back({m_last[1], m_data[1]});
    if (m_valid[2] && m_ready[2]) q2.push_back({m_last[2], m_data[2]});
    for (int k = 0; k < 3; k++)
      if (s_valid[k] && s_ready[k]) acc[k] <= acc[k] + 1;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mkbeat(input int idx, input int cnt, input longint first);
    rheed_beat_t b;
    b = '0;
    b.frame_idx = idx[11:0];
    b.count     = cnt[3:0];
    for (int i = 0; i < cnt; i++) b.slot[i] = 40'(first + i);
    return b;
  endfunction

  task automatic pop_chk(input int k, input string tag, input logic exp_last,
                         input logic [255:0] exp_data);
    logic [256:0] b;
    int sz;
    sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      chk({tag, "_present"}, 256'd0, 256'd1);
      return;
    end
    if (k == 0) b = q0.pop_front();
    else if (k == 1) b = q1.pop_front();
    else b = q2.pop_front();
    chk({tag, "_last"}, {255'd0, b[256]}, {255'd0, exp_last});
    chk({tag, "_data"}, b[255:0], exp_data);
  endtask

  // Feeds n sequential values starting at 'first'; handshake decided just before each edge.
  task automatic stream(input int k, input longint first, input int n, output int cyc);
    int sent;
    logic hs;
    sent = 0;
    cyc  = 0;
    s_valid[k] = 1'b1;
    s_data[k]  = 40'(first);
    while (sent < n && cyc < 20000) begin
      @(negedge clk);
      hs = s_ready[k];
      tick();
      cyc++;
      if (hs) begin
        sent++;
        s_data[k] = 40'(first + sent);
      end
    end
    s_valid[k] = 1'b0;
    if (sent < n) chk("stream_timeout", 256'(sent), 256'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    tick();
  endtask

  initial begin
    int cyc, a0, bad;
    logic [256:0] b;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_valid[k] = 1'b0;
      s_data[k]  = '0;
      m_ready[k] = 1'b0;
    end
    tick();
    chk("rst_sready", {255'd0, s_ready[1]}, 256'd0);
    chk("rst_mvalid", {255'd0, m_valid[1]}, 256'd0);
    chk("rst_mdata", m_data[1], 256'd0);
    chk("rst_mlast", {255'd0, m_last[1]}, 256'd0);
    chk("rst_fdone", {255'd0, fd[1]}, 256'd0);
    chk("rst_fidx", {244'd0, fidx[1]}, 256'd0);
    reset = 1'b0;
    tick();
    chk("idle_sready", {255'd0, s_ready[1]}, 256'd1);

    // Single result frame: one beat, latency one cycle, frame_done after drain.
    m_ready[0] = 1'b1;
    s_valid[0] = 1'b1;
    s_data[0]  = 40'h12_3456_789A;
    chk("one_pre_mvalid", {255'd0, m_valid[0]}, 256'd0);
    tick();
    s_valid[0] = 1'b0;
    chk("one_mvalid", {255'd0, m_valid[0]}, 256'd1);
    chk("one_mlast", {255'd0, m_last[0]}, 256'd1);
    chk("one_mdata", m_data[0], mkbeat(0, 1, 40'h12_3456_789A));
    chk("one_fidx", {244'd0, fidx[0]}, 256'd1);
    tick();
    chk("one_fdone", {255'd0, fd[0]}, 256'd1);
    chk("one_drained", {255'd0, m_valid[0]}, 256'd0);
    tick();
    chk("one_fdone_pulse", {255'd0, fd[0]}, 256'd0);
    pop_chk(0, "one_q", 1'b1, mkbeat(0, 1, 40'h12_3456_789A));

    // 13 results per frame, then six results of the next frame.
    m_ready[1] = 1'b1;
    stream(1, 1, 19, cyc);
    chk("f13_tput", 256'(cyc), 256'd19);
    repeat (3) tick();
    pop_chk(1, "f13_b0", 1'b0, mkbeat(0, 6, 1));
    pop_chk(1, "f13_b1", 1'b0, mkbeat(0, 6, 7));
    pop_chk(1, "f13_b2", 1'b1, mkbeat(0, 1, 13));
    pop_chk(1, "f13_b3", 1'b0, mkbeat(1, 6, 14));
    chk("f13_extra", 256'(q1.size()), 256'd0);

    // Back-pressure: ready low for 20 cycles.
    do_reset();
    m_ready[1] = 1'b0;
    a0 = acc[1];
    fork
      stream(1, 1, 13, cyc);
      begin
        repeat (10) tick();
        chk("bp_acc6", 256'(acc[1] - a0), 256'd6);
        chk("bp_sready", {255'd0, s_ready[1]}, 256'd0);
        chk("bp_mvalid", {255'd0, m_valid[1]}, 256'd1);
        chk("bp_hold", m_data[1], mkbeat(0, 6, 1));
        repeat (10) tick();
        m_ready[1] = 1'b1;
      end
    join
    repeat (3) tick();
    pop_chk(1, "bp_b0", 1'b0, mkbeat(0, 6, 1));
    pop_chk(1, "bp_b1", 1'b0, mkbeat(0, 6, 7));
    pop_chk(1, "bp_b2", 1'b1, mkbeat(0, 1, 13));
    chk("bp_acc13", 256'(acc[1] - a0), 256'd13);

    // Reset after three accepted results discards the partial frame.
    stream(1, 100, 3, cyc);
    reset = 1'b1;
    #1;
    chk("rstmid_sready", {255'd0, s_ready[1]}, 256'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rstmid_nobeat", 256'(q1.size()), 256'd0);
    chk("rstmid_fidx", {244'd0, fidx[1]}, 256'd0);
    stream(1, 200, 6, cyc);
    repeat (2) tick();
    pop_chk(1, "rstmid_b0", 1'b0, mkbeat(0, 6, 200));

    // Six results per frame: one full beat per frame, each with tlast.
    do_reset();
    m_ready[2] = 1'b1;
    stream(2, 50, 12, cyc);
    repeat (2) tick();
    pop_chk(2, "f6_b0", 1'b1, mkbeat(0, 6, 50));
    pop_chk(2, "f6_b1", 1'b1, mkbeat(1, 6, 56));

    // 4097 single-result frames: drain and completion coincide every cycle; index wraps.
    do_reset();
    m_ready[0] = 1'b1;
    stream(0, 1, 4097, cyc);
    chk("wrap_tput", 256'(cyc), 256'd4097);
    chk("wrap_mvalid_held", {255'd0, m_valid[0]}, 256'd1);
    repeat (2) tick();
    chk("wrap_count", 256'(q0.size()), 256'd4097);
    bad = 0;
    for (int i = 0; i < 4097 && q0.size() > 0; i++) begin
      b = q0.pop_front();
      if (b !== {1'b1, mkbeat(i % 4096, 1, i + 1)}) bad++;
      if (i == 4095) chk("wrap_idx4095", {244'd0, b[255:244]}, 256'd4095);
      if (i == 4096) chk("wrap_idx0", {244'd0, b[255:244]}, 256'd0);
    end
    chk("wrap_all_beats", 256'(bad), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
